// File: rtl/multicycle_pc_controller.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the PC-update datapath.
// Outputs decode combinationally from the current state and this cycle's ready/decoded inputs.
module multicycle_pc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             branch,
    input  logic             bcond,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             is_halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= S_IF;
            cnt <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nxt        = cur;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        is_halted  = 1'b0;
        case (cur)
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    nxt      = S_ID;
                end
            end
            S_ID: nxt = S_EX;
            S_EX: begin
                if (is_halt) begin
                    nxt    = S_HALT;
                    retire = 1'b1;
                end else if (branch) begin
                    pc_write = 1'b1;
                    pc_src   = {1'b0, bcond};
                    retire   = 1'b1;
                    nxt      = S_IF;
                end else if (is_load || is_store) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_read  = is_load;
                dmem_write = is_store;
                // A load finishes in WB; anything else completes here and advances the PC.
                if (dmem_ready) begin
                    if (is_load) begin
                        nxt = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        nxt      = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                pc_src    = is_jalr ? 2'd2 : (is_jal ? 2'd1 : 2'd0);
                nxt       = S_IF;
            end
            S_HALT: is_halted = 1'b1;
            default: nxt = S_IF;
        endcase
        // Reset overrides every output, independent of the registered state.
        if (reset) begin
            retire     = 1'b0;
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            reg_write  = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            is_halted  = 1'b0;
        end
    end

    assign state   = reset ? 3'd0 : cur;
    assign retired = reset ? '0 : cnt;

endmodule

// File: tb/tb_multicycle_pc_controller.sv
// Randomized instruction-level bench for multicycle_pc_controller, with a 2-bit counter twin for wrap.
module tb_multicycle_pc_controller;

    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_JAL = 4, K_JALR = 5, K_JJ = 6, K_HALT = 7;

    logic clk = 1'b0;
    logic reset, is_jal, is_jalr, branch, bcond, is_load, is_store, is_halt, imem_ready, dmem_ready;
    logic imem_req, ir_write, dmem_read, dmem_write, reg_write, pc_write, is_halted;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic [31:0] retired;
    logic imem_req2, ir_write2, dmem_read2, dmem_write2, reg_write2, pc_write2, is_halted2;
    logic [1:0]  pc_src2;
    logic [2:0]  state2;
    logic [1:0]  retired2;
    logic [8:0]  outs;

    int unsigned mdl = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_pc_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .is_jal(is_jal), .is_jalr(is_jalr), .branch(branch),
        .bcond(bcond), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src), .state(state),
        .is_halted(is_halted), .retired(retired)
    );

    multicycle_pc_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .is_jal(is_jal), .is_jalr(is_jalr), .branch(branch),
        .bcond(bcond), .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req2),
        .ir_write(ir_write2), .dmem_read(dmem_read2), .dmem_write(dmem_write2),
        .reg_write(reg_write2), .pc_write(pc_write2), .pc_src(pc_src2), .state(state2),
        .is_halted(is_halted2), .retired(retired2)
    );

    // {imem_req, ir_write, dmem_read, dmem_write, reg_write, pc_write, pc_src[1:0], is_halted}
    assign outs = {imem_req, ir_write, dmem_read, dmem_write, reg_write, pc_write, pc_src, is_halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic exp_cyc(input string tag, input logic [2:0] st, input logic [8:0] v);
        @(negedge clk);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".outs"}, 32'(outs), 32'(v));
        check({tag, ".retired"}, retired, mdl);
        check({tag, ".retired_w2"}, 32'(retired2), mdl % 4);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_flags();
        {is_jal, is_jalr, branch, bcond, is_load, is_store, is_halt} = 7'($urandom);
    endtask

    task automatic set_flags(input int kind, input bit bc);
        is_jal   = (kind == K_JAL) || (kind == K_JJ);
        is_jalr  = (kind == K_JALR) || (kind == K_JJ);
        branch   = (kind == K_BR);
        bcond    = bc;
        is_load  = (kind == K_LD);
        is_store = (kind == K_ST);
        is_halt  = (kind == K_HALT);
    endtask

    task automatic do_instr(input int kind, input bit bc, input int iw, input int mw);
        logic [1:0] src;
        for (int i = 0; i < iw; i++) begin
            imem_ready = 1'b0; dmem_ready = 1'($urandom); rand_flags();
            exp_cyc("if_wait", 3'd0, 9'h100);
        end
        imem_ready = 1'b1; rand_flags();
        exp_cyc("if_rdy", 3'd0, 9'h180);
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom); rand_flags();
        exp_cyc("id", 3'd1, 9'h000);
        set_flags(kind, bc);
        if (kind == K_HALT) begin
            exp_cyc("ex_halt", 3'd2, 9'h000);
            mdl++;
            return;
        end
        if (kind == K_BR) begin
            exp_cyc("ex_br", 3'd2, {5'b00000, 1'b1, 1'b0, bc, 1'b0});
            mdl++;
            return;
        end
        exp_cyc("ex", 3'd2, 9'h000);
        if (kind == K_LD || kind == K_ST) begin
            for (int i = 0; i < mw; i++) begin
                dmem_ready = 1'b0; imem_ready = 1'($urandom); bcond = 1'($urandom);
                exp_cyc("mem_wait", 3'd3, (kind == K_LD) ? 9'h040 : 9'h020);
            end
            dmem_ready = 1'b1;
            if (kind == K_ST) begin
                exp_cyc("mem_st", 3'd3, 9'h028);
                mdl++;
                return;
            end
            exp_cyc("mem_ld", 3'd3, 9'h040);
        end
        src = (kind == K_JALR || kind == K_JJ) ? 2'd2 : (kind == K_JAL) ? 2'd1 : 2'd0;
        exp_cyc("wb", 3'd4, {4'b0000, 1'b1, 1'b1, src, 1'b0});
        mdl++;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; set_flags(K_ALU, 1'b0);
        #1;
        exp_cyc("reset0", 3'd0, 9'h000);
        exp_cyc("reset1", 3'd0, 9'h000);
        reset = 1'b0;

        do_instr(K_ALU, 1'b0, 0, 0);
        do_instr(K_BR, 1'b1, 0, 0);
        do_instr(K_BR, 1'b0, 1, 0);
        do_instr(K_LD, 1'b0, 0, 3);
        do_instr(K_JJ, 1'b0, 0, 0);
        do_instr(K_JAL, 1'b0, 2, 0);
        do_instr(K_ST, 1'b0, 0, 2);

        for (int n = 0; n < 150; n++)
            do_instr(int'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        // halt, hold, then reset out of HALT
        do_instr(K_HALT, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            {imem_ready, dmem_ready} = 2'($urandom); rand_flags();
            exp_cyc("halt", 3'd5, 9'h001);
        end
        reset = 1'b1; mdl = 0;
        exp_cyc("rst_halt", 3'd0, 9'h000);
        reset = 1'b0; imem_ready = 1'b0;
        exp_cyc("after_halt", 3'd0, 9'h100);

        // reset in the middle of a MEM wait
        do_instr(K_ALU, 1'b0, 0, 0);
        imem_ready = 1'b1;
        exp_cyc("m_if", 3'd0, 9'h180);
        exp_cyc("m_id", 3'd1, 9'h000);
        set_flags(K_LD, 1'b0); dmem_ready = 1'b0;
        exp_cyc("m_ex", 3'd2, 9'h000);
        exp_cyc("m_wait", 3'd3, 9'h040);
        reset = 1'b1; mdl = 0;
        exp_cyc("rst_mem", 3'd0, 9'h000);
        reset = 1'b0; imem_ready = 1'b0;
        exp_cyc("after_mem", 3'd0, 9'h100);

        // five instructions from zero: 2-bit twin must read 1
        for (int i = 0; i < 5; i++)
            do_instr(K_ALU, 1'b0, 0, 0);
        @(negedge clk);
        check("wrap_w2", 32'(retired2), 32'd1);
        check("wrap_w32", retired, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_pc_controller.md
Name: multicycle_pc_controller

Overview:
- Multi-cycle sequencer for the PC-update datapath: IF, ID, EX, MEM and WB steps for each instruction.
- Decides when the PC register is written and which next-PC source is used (pc+4, branch/jal target, jalr target).
- Drives instruction-fetch, data-memory and register-write enables, using ready handshakes to both memories.
- Sits between the decoder/ALU outputs and the PC register, next-PC mux and memories; maintains a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- is_jal  input  1  decoded JAL; valid from ID onward.
- is_jalr  input  1  decoded JALR; valid from ID onward.
- branch  input  1  decoded conditional branch.
- bcond  input  1  branch condition from the ALU; valid in EX.
- is_load  input  1  decoded load.
- is_store  input  1  decoded store.
- is_halt  input  1  decoded halt (ecall with x17==10); valid from ID onward.
- imem_ready  input  1  instruction memory returns data this cycle.
- dmem_ready  input  1  data memory completes its access this cycle.
- imem_req  output  1  instruction fetch request.
- ir_write  output  1  latch the instruction register.
- dmem_read  output  1  data-memory read request.
- dmem_write  output  1  data-memory write request.
- reg_write  output  1  register-file write enable.
- pc_write  output  1  PC register load enable.
- pc_src  output  2  next-PC select: 0 = pc+4, 1 = branch/jal target, 2 = jalr target; 3 is never driven.
- state  output  3  current state encoding, for debug.
- is_halted  output  1  the core has halted.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and return to IF on the next cycle.
- Reset:
  - A cycle with reset=1 sets state=IF and retired=0 on that edge.
  - While reset=1, every output is 0 (including imem_req and pc_src), regardless of the current state.
  - Reset is honoured in any state, including mid-wait in IF or MEM and in HALT.
- Output timing: outputs decode combinationally from state plus the current-cycle ready inputs and decoded flags. There is no extra output register.
- IF:
  - imem_req=1.
  - If imem_ready=1: ir_write=1, next state ID.
  - Otherwise remain in IF, with imem_req held high, for any number of cycles.
- ID: all enables 0; next state EX unconditionally.
- EX:
  - If is_halt: next state HALT.
  - Else if branch: pc_write=1; pc_src=1 if bcond, else 0; next state IF. The instruction retires.
  - Else if is_load or is_store: next state MEM.
  - Otherwise: next state WB.
- MEM:
  - dmem_read=is_load; dmem_write=is_store.
  - Stay in MEM until dmem_ready=1.
  - On the ready cycle with a store: pc_write=1, pc_src=0, next state IF; the instruction retires.
  - On the ready cycle with a load: next state WB, no pc_write.
- WB:
  - reg_write=1, pc_write=1, next state IF; the instruction retires.
  - pc_src=2 if is_jalr; else 1 if is_jal; else 0. is_jalr takes priority if both are set.
- HALT:
  - is_halted=1; all other enables 0; state is held until reset.
  - The halt instruction counts as retired once, on the EX->HALT transition.
- pc_write is asserted exactly once per non-halt instruction, and never in the same cycle as imem_req.
- retired increments by 1 on each retiring cycle. It wraps modulo 2^CNT_W; no saturation.
- Decoded flags are sampled only in the state that uses them. Changes to them in other states have no effect.

Test Plan:
- ALU op, imem_ready and dmem_ready always 1 -> state sequence 0,1,2,4,0. pc_write=1 with pc_src=0 only in WB; retired=1 after 5 edges.
- Branch with bcond=1 -> 3-cycle instruction; pc_write=1 and pc_src=1 in EX; no reg_write. Repeat with bcond=0 -> pc_src=0.
- Load with dmem_ready low for 3 cycles -> MEM held for 4 cycles with dmem_read=1; then WB with reg_write=1 and pc_src=0; 8 cycles total.
- JALR with is_jal also set -> WB drives pc_src=2. JAL alone -> pc_src=1. Both instructions have reg_write=1.
- Halt in EX -> HALT with is_halted=1 and retired incremented once. 10 more cycles -> no enables asserted. Reset pulse -> state=0, retired=0, imem_req=1 on the following cycle.
- Reset asserted during a MEM wait -> all outputs 0 in the reset cycle; next cycle state=IF and retired=0. With CNT_W=2, 5 instructions -> retired=1 (wrap).
